bundle_cmd_queue: RTL
=====================

// Module: bundle_cmd_queue
// PURPOSE
//  Command queue and sequencer directly upstream of the bundle kernel mapper. Buffers bundle commands
//  (hva, hvb, hvc, length, mode, tag), issues them one at a time on the mapper's valid/done
//  interface and returns a one-cycle completion pulse carrying the tag. Zero-length commands
//  never reach the mapper; they are completed locally with an error.
// PARAMETERS
//  HV_ADDRESS_WIDTH  20  width of hypervector base addresses and vec_length
//  QUEUE_DEPTH        4  command FIFO entries; power of two, >=2
//  TAG_WIDTH          4  opaque command tag width
//  TIMEOUT_CYCLES 65535  watchdog limit per dispatched command (used only with BUNDLE_CMDQ_WATCHDOG_EN)
// PORTS
//  clk             in   1       clock; all logic on rising edge
//  reset           in   1       synchronous, active-high reset
//  cmd_valid       in   1       command offered
//  cmd_ready       out  1       queue can accept; equals !full
//  cmd_length      in   HV_ADDRESS_WIDTH  vector length in words
//  cmd_hva/hvb/hvc in   HV_ADDRESS_WIDTH  operand A, operand B, result base addresses
//  cmd_mode        in   1       0 = A&B, 1 = A->B
//  cmd_tag         in   TAG_WIDTH
//  map_valid       out  1       one-cycle start pulse to the mapper
//  map_vec_length, map_hva, map_hvb, map_hvc  out  HV_ADDRESS_WIDTH  registered, stable from pulse to done
//  map_mode        out  1
//  map_done        in   1       mapper idle/complete; high when idle
//  cpl_valid       out  1       one-cycle completion pulse; no backpressure
//  cpl_tag         out  TAG_WIDTH
//  cpl_err         out  1       zero-length command, or watchdog fired during this command
//  occupancy       out  $clog2(QUEUE_DEPTH)+1  entries held, excluding the in-flight command
//  idle            out  1       FIFO empty and FSM in S_IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1 and idle=1. FIFO empties and FSM goes to S_IDLE.
//    Reset mid-command drops the queue silently and generates no completion.
//  Accept: a command is pushed on a cycle with cmd_valid & cmd_ready.
//    At full, the push is refused even when a pop happens in the same cycle (cmd_ready=!full).
//    occupancy updates the cycle after the push or pop.
//  FSM:
//   S_IDLE:      if FIFO not empty and map_done=1, pop the head into the map_* registers.
//                  length==0 -> S_REJECT.
//                  otherwise -> S_ISSUE.
//   S_REJECT:    cpl_valid=1, cpl_err=1, cpl_tag=head tag; no map_valid -> S_IDLE.
//   S_ISSUE:     map_valid=1 for exactly this cycle -> S_WAIT_LOW.
//   S_WAIT_LOW:  wait for map_done=0 -> S_WAIT_HIGH.
//   S_WAIT_HIGH: wait for map_done=1, then cpl_valid=1, cpl_tag, cpl_err=wd_flag -> S_IDLE.
//  Latency: a push into an empty, idle queue at cycle N gives map_valid at N+2.
//    A completion pulse arrives on the cycle map_done is first seen high again in S_WAIT_HIGH.
//    Back-to-back commands: the next map_valid comes at the earliest 2 cycles after cpl_valid.
//  map_* outputs hold their value from S_ISSUE until the next pop; they never change while the mapper is busy.
//  A push in the same cycle as a pop of the last entry is legal; occupancy stays 1.
//  Pointers wrap modulo QUEUE_DEPTH; full/empty are resolved with an extra pointer bit.
// CONFIGURATION
//  BUNDLE_CMDQ_WATCHDOG_EN defined:
//   - A cycle counter runs in S_WAIT_LOW/S_WAIT_HIGH.
//   - When it reaches TIMEOUT_CYCLES, wd_flag is set. The FSM keeps waiting on map_done and issues nothing new.
//   - The eventual completion reports cpl_err=1.
//   - Extra output wd_timeout (1 bit) is sticky until reset.
//  Not defined: no counter or wd_timeout port; wd_flag is tied to 0; the FSM waits indefinitely.
// STRUCTURE
//  Package bundle_cmdq_pkg holds:
//   - BundleCmdQ_State_t enum {S_IDLE, S_REJECT, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH}
//   - bundle_cmd_t packed struct {length, hva, hvb, hvc, mode, tag}
//  Sub-module bundle_cmd_fifo: synchronous FIFO of bundle_cmd_t with first-word-fall-through
//    head, push/pop, full/empty/count.
//  Top level: FSM, map_* registers and the optional watchdog.
// TESTING
//  1. Push {len=8,hva=0x100,hvb=0x200,hvc=0x300,mode=0,tag=3} into an idle queue.
//     -> map_valid pulse at N+2 with those values; model drops map_done for 10 cycles;
//        then cpl_valid=1, cpl_tag=3, cpl_err=0.
//  2. Push len=0, tag=5.
//     -> no map_valid; cpl_valid=1, cpl_tag=5, cpl_err=1 two cycles after the push.
//  3. Hold the mapper busy and push 5 commands (QUEUE_DEPTH=4).
//     -> 1 in flight + 4 queued; cmd_ready=0 at occupancy=4;
//        completions in order with tags 0..4, one map_valid per command.
//  4. Simultaneous push and pop of the last entry.
//     -> occupancy stays 1, no command lost or duplicated.
//  5. Assert reset in S_WAIT_HIGH with 2 queued.
//     -> next cycle idle=1, occupancy=0, no cpl_valid; later map_done rise ignored.
//  6. (WATCHDOG_EN, TIMEOUT_CYCLES=16) map_done held low 40 cycles.
//     -> wd_timeout=1 after 16; completion at done rise with cpl_err=1.

Source files
------------

// File: rtl/bundle_cmdq_pkg.sv
// Shared types for the bundle command queue: FSM states and the command payload.
package bundle_cmdq_pkg;

    localparam int unsigned HV_ADDRESS_WIDTH = 20;
    localparam int unsigned TAG_WIDTH        = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REJECT,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH
    } BundleCmdQ_State_t;

    typedef struct packed {
        logic [HV_ADDRESS_WIDTH-1:0] length;
        logic [HV_ADDRESS_WIDTH-1:0] hva;
        logic [HV_ADDRESS_WIDTH-1:0] hvb;
        logic [HV_ADDRESS_WIDTH-1:0] hvc;
        logic                        mode;
        logic [TAG_WIDTH-1:0]        tag;
    } bundle_cmd_t;

    // Zero-length commands are completed locally and never reach the mapper.
    function automatic logic is_zero_length(input bundle_cmd_t cmd);
        return cmd.length == '0;
    endfunction

endpackage

// File: rtl/bundle_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO of bundle commands.
// Full/empty are resolved with one extra pointer bit.
module bundle_cmd_fifo
    import bundle_cmdq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  bundle_cmd_t              wr_data,
    output bundle_cmd_t              head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    bundle_cmd_t      mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push at full is refused even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
    end

    assign head  = mem[rd_ptr[PTR_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/bundle_cmd_queue.sv
// Command queue and sequencer in front of the bundle kernel mapper.
// Optional watchdog enabled with `define BUNDLE_CMDQ_WATCHDOG_EN.
module bundle_cmd_queue
    import bundle_cmdq_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4
`ifdef BUNDLE_CMDQ_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [HV_ADDRESS_WIDTH-1:0]    cmd_length,
    input  logic [HV_ADDRESS_WIDTH-1:0]    cmd_hva,
    input  logic [HV_ADDRESS_WIDTH-1:0]    cmd_hvb,
    input  logic [HV_ADDRESS_WIDTH-1:0]    cmd_hvc,
    input  logic                           cmd_mode,
    input  logic [TAG_WIDTH-1:0]           cmd_tag,
    output logic                           map_valid,
    output logic [HV_ADDRESS_WIDTH-1:0]    map_vec_length,
    output logic [HV_ADDRESS_WIDTH-1:0]    map_hva,
    output logic [HV_ADDRESS_WIDTH-1:0]    map_hvb,
    output logic [HV_ADDRESS_WIDTH-1:0]    map_hvc,
    output logic                           map_mode,
    input  logic                           map_done,
    output logic                           cpl_valid,
    output logic [TAG_WIDTH-1:0]           cpl_tag,
    output logic                           cpl_err,
    output logic [$clog2(QUEUE_DEPTH):0]   occupancy,
    output logic                           idle
`ifdef BUNDLE_CMDQ_WATCHDOG_EN
    ,
    output logic                           wd_timeout
`endif
);

    BundleCmdQ_State_t state;
    BundleCmdQ_State_t state_next;
    bundle_cmd_t       cmd_in;
    bundle_cmd_t       fifo_head;
    bundle_cmd_t       cur_cmd;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              wd_flag;

    assign cmd_in = '{length: cmd_length, hva: cmd_hva, hvb: cmd_hvb,
                      hvc: cmd_hvc, mode: cmd_mode, tag: cmd_tag};

    bundle_cmd_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (cmd_valid),
        .pop     (fifo_pop),
        .wr_data (cmd_in),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (occupancy)
    );

    assign cmd_ready = !fifo_full;
    assign idle      = fifo_empty && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cur_cmd <= '0;
        end else begin
            state <= state_next;
            if (fifo_pop) cur_cmd <= fifo_head;
        end
    end

    // Completion is flagged on the same cycle map_done is seen high in S_WAIT_HIGH.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        map_valid  = 1'b0;
        cpl_valid  = 1'b0;
        cpl_tag    = '0;
        cpl_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && map_done) begin
                    fifo_pop   = 1'b1;
                    state_next = is_zero_length(fifo_head) ? S_REJECT : S_ISSUE;
                end
            end
            S_REJECT: begin
                cpl_valid  = 1'b1;
                cpl_err    = 1'b1;
                cpl_tag    = cur_cmd.tag;
                state_next = S_IDLE;
            end
            S_ISSUE: begin
                map_valid  = 1'b1;
                state_next = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!map_done) state_next = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (map_done) begin
                    cpl_valid  = 1'b1;
                    cpl_err    = wd_flag;
                    cpl_tag    = cur_cmd.tag;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign map_vec_length = cur_cmd.length;
    assign map_hva        = cur_cmd.hva;
    assign map_hvb        = cur_cmd.hvb;
    assign map_hvc        = cur_cmd.hvc;
    assign map_mode       = cur_cmd.mode;

`ifdef BUNDLE_CMDQ_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            waiting;

    assign waiting = (state == S_WAIT_LOW) || (state == S_WAIT_HIGH);

    // Per-command cycle counter; the flag only taints the completion, the FSM keeps waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt     <= '0;
            wd_flag    <= 1'b0;
            wd_timeout <= 1'b0;
        end else if (fifo_pop) begin
            wd_cnt  <= '0;
            wd_flag <= 1'b0;
        end else if (waiting) begin
            if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wd_flag    <= 1'b1;
                wd_timeout <= 1'b1;
            end
        end
    end
`else
    assign wd_flag = 1'b0;
`endif

endmodule
